mem_bus_unit: RTL and testbench

- Memory access stage that sits directly downstream of the core microcoded control unit.
- Consumes the control unit's mem_read/mem_write requests plus the datapath address, store data and access width.
- Drives a single-outstanding valid/ready system bus with byte enables, and returns mem_complete with aligned, extended load data.
- Detects misaligned accesses and bus errors; both are reported to the exception logic.

---
 rtl/mem_bus_unit_pkg.sv | 50 +++++
 rtl/mem_bus_unit_lane_align.sv | 50 +++++
 rtl/mem_bus_unit.sv | 200 ++++++++++++++++++++
 tb/tb_mem_bus_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_unit_pkg.sv
// mem_bus_unit_pkg: shared types and constants for the memory access stage.
//   - funct3 load/store width encodings (RV32 ISA values)
//   - mem_fault_cause encodings
//   - FSM state enum and the latched bus request payload
//   - is_misaligned(): natural-alignment check for an access
package mem_bus_unit_pkg;

    localparam int unsigned XLEN_W = 32;

    // ISA funct3 encodings; stores share the low two bits (SB=000, SH=001, SW=010)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] CAUSE_MISALIGNED = 2'd0;
    localparam logic [1:0] CAUSE_BUS_ERR    = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    // Request as presented on the bus, plus what the load path needs later
    typedef struct packed {
        logic                write;
        logic [XLEN_W-3:0]   word_addr;
        logic [3:0]          be;
        logic [XLEN_W-1:0]   wdata;
        logic [2:0]          f3;
        logic [1:0]          lo;
    } bus_req_t;

    // Halfwords need even addresses, words need 4-byte alignment
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (size)
            2'b01:   mis = lo[0];
            2'b10:   mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_bus_unit_lane_align.sv
// mem_lane_align: combinational byte-lane steering.
//   Store side: st_size_i/st_lo_i/st_data_i -> be_c_o, st_data_c_o (replicated lanes)
//   Load side:  ld_f3_i/ld_lo_i/ld_data_i   -> ld_data_c_o (shifted, sign/zero extended)
module mem_lane_align
    import mem_bus_unit_pkg::*;
(
    input  logic [1:0]        st_size_i,
    input  logic [1:0]        st_lo_i,
    input  logic [XLEN_W-1:0] st_data_i,
    input  logic [2:0]        ld_f3_i,
    input  logic [1:0]        ld_lo_i,
    input  logic [XLEN_W-1:0] ld_data_i,
    output logic [3:0]        be_c_o,
    output logic [XLEN_W-1:0] st_data_c_o,
    output logic [XLEN_W-1:0] ld_data_c_o
);

    logic [XLEN_W-1:0] ld_shift_c;

    // Store lanes: replicate narrow data so every lane carries it; be picks the lane
    always_comb begin
        be_c_o      = 4'hF;
        st_data_c_o = st_data_i;
        case (st_size_i)
            2'b00: begin
                be_c_o      = 4'(4'b0001 << st_lo_i);
                st_data_c_o = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                be_c_o      = 4'(4'b0011 << st_lo_i);
                st_data_c_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extract: bring the addressed byte to lane 0, then extend
    always_comb begin
        ld_shift_c  = ld_data_i >> {ld_lo_i, 3'b000};
        ld_data_c_o = ld_shift_c;
        case (ld_f3_i)
            F3_LB:   ld_data_c_o = {{24{ld_shift_c[7]}}, ld_shift_c[7:0]};
            F3_LBU:  ld_data_c_o = {24'h0, ld_shift_c[7:0]};
            F3_LH:   ld_data_c_o = {{16{ld_shift_c[15]}}, ld_shift_c[15:0]};
            F3_LHU:  ld_data_c_o = {16'h0, ld_shift_c[15:0]};
            default: ld_data_c_o = ld_shift_c;
        endcase
    end

endmodule

// File: rtl/mem_bus_unit.sv
// mem_bus_unit: memory access stage between the control unit and a
// single-outstanding valid/ready system bus.
//   Control side: mem_read, mem_write, addr, size_f3, wdata ->
//                 mem_complete, rdata, mem_fault, mem_fault_cause
//   Bus side:     bus_valid, bus_write, bus_addr, bus_be, bus_wdata ->
//                 bus_ready, bus_rdata, bus_err
// Optional: define MEM_BUS_UNIT_TIMEOUT_EN to abort a BUSY access after
// TIMEOUT_CYCLES cycles without bus_ready (cause 2).
module mem_bus_unit
    import mem_bus_unit_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [XLEN-1:0] addr,
    input  logic [2:0]      size_f3,
    input  logic [XLEN-1:0] wdata,
    output logic            mem_complete,
    output logic [XLEN-1:0] rdata,
    output logic            mem_fault,
    output logic [1:0]      mem_fault_cause,
    output logic            bus_valid,
    output logic            bus_write,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_ready,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_err
);

    state_e            state_q, state_d;
    bus_req_t          req_q, req_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic [1:0]        cause_q, cause_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              kill_q, kill_d;

    logic              req_c;
    logic              live_c;
    logic              misalign_c;
    logic              tmo_hit_c;
    logic [3:0]        be_c;
    logic [XLEN_W-1:0] st_data_c;
    logic [XLEN_W-1:0] ld_data_c;

    assign req_c      = mem_read | mem_write;
    assign live_c     = req_c & ~kill_q;
    assign misalign_c = is_misaligned(size_f3[1:0], addr[1:0]);

    mem_lane_align u_lane (
        .st_size_i   (size_f3[1:0]),
        .st_lo_i     (addr[1:0]),
        .st_data_i   (wdata),
        .ld_f3_i     (req_q.f3),
        .ld_lo_i     (req_q.lo),
        .ld_data_i   (bus_rdata),
        .be_c_o      (be_c),
        .st_data_c_o (st_data_c),
        .ld_data_c_o (ld_data_c)
    );

`ifdef MEM_BUS_UNIT_TIMEOUT_EN
    localparam int unsigned TmoW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TmoW-1:0] tmo_q, tmo_d;

    // Counts BUSY cycles without bus_ready; zero whenever not waiting
    always_comb begin
        tmo_d = '0;
        if (state_q == ST_BUSY && !bus_ready) begin
            tmo_d = tmo_q + TmoW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_hit_c = (state_q == ST_BUSY) && !bus_ready &&
                       (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout a BUSY access waits for bus_ready indefinitely
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign tmo_hit_c      = 1'b0;
`endif

    // Next state and next registered outputs
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        fault_d = 1'b0;
        cause_d = cause_q;
        rdata_d = rdata_q;
        kill_d  = kill_q;

        case (state_q)
            ST_IDLE: begin
                kill_d = 1'b0;
                if (req_c) begin
                    if (misalign_c) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                        cause_d = CAUSE_MISALIGNED;
                    end else begin
                        req_d.write     = mem_write;
                        req_d.word_addr = addr[XLEN-1:2];
                        req_d.be        = be_c;
                        req_d.wdata     = st_data_c;
                        req_d.f3        = size_f3;
                        req_d.lo        = addr[1:0];
                        valid_d         = 1'b1;
                        state_d         = ST_BUSY;
                    end
                end
            end

            ST_BUSY: begin
                // A dropped request is remembered so the access finishes silently
                if (!req_c) begin
                    kill_d = 1'b1;
                end
                if (bus_ready) begin
                    if (!live_c) begin
                        state_d = ST_IDLE;
                    end else if (bus_err) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                        cause_d = CAUSE_BUS_ERR;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        rdata_d = ld_data_c;
                    end
                end else if (tmo_hit_c) begin
                    if (live_c) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                        cause_d = CAUSE_TIMEOUT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end

            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= 2'd0;
            rdata_q <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            rdata_q <= rdata_d;
            kill_q  <= kill_d;
        end
    end

    assign mem_complete    = done_q;
    assign rdata           = rdata_q;
    assign mem_fault       = fault_q;
    assign mem_fault_cause = cause_q;
    assign bus_valid       = valid_q;
    assign bus_write       = req_q.write;
    assign bus_addr        = {req_q.word_addr, 2'b00};
    assign bus_be          = req_q.be;
    assign bus_wdata       = req_q.wdata;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed bench for mem_bus_unit: a vector table of single accesses with
// one-cycle bus_ready, plus hand sequences for faults, stalls, dropped
// requests and reset in BUSY.
module tb_mem_bus_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata;
    logic [2:0]  size_f3;
    logic        mem_complete, mem_fault;
    logic [31:0] rdata;
    logic [1:0]  mem_fault_cause;
    logic        bus_valid, bus_write;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_ready, bus_err;

    always #5 clk = ~clk;

    mem_bus_unit #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .addr            (addr),
        .size_f3         (size_f3),
        .wdata           (wdata),
        .mem_complete    (mem_complete),
        .rdata           (rdata),
        .mem_fault       (mem_fault),
        .mem_fault_cause (mem_fault_cause),
        .bus_valid       (bus_valid),
        .bus_write       (bus_write),
        .bus_addr        (bus_addr),
        .bus_be          (bus_be),
        .bus_wdata       (bus_wdata),
        .bus_ready       (bus_ready),
        .bus_rdata       (bus_rdata),
        .bus_err         (bus_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Outputs are registered: sample 1 time unit after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brdata;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic        chk_rd;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[11];

    initial begin
        //          we    f3      addr        wdata         brdata        be       baddr       bwdata        chk   rd
        vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 4'hF,    32'h100, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80123456, 4'b1000, 32'h100, 32'h0,        1'b1, 32'hFFFFFF80};
        vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h80123456, 4'b1000, 32'h100, 32'h0,        1'b1, 32'h00000080};
        vecs[3]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80123456, 4'b1100, 32'h100, 32'h0,        1'b1, 32'hFFFF8012};
        vecs[4]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h80123456, 4'b1100, 32'h100, 32'h0,        1'b1, 32'h00008012};
        vecs[5]  = '{1'b0, 3'b000, 32'h101, 32'h0,        32'h12345678, 4'b0010, 32'h100, 32'h0,        1'b1, 32'h00000056};
        vecs[6]  = '{1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0,        4'b1100, 32'h200, 32'hABCDABCD, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 3'b000, 32'h301, 32'h123456EF, 32'h0,        4'b0010, 32'h300, 32'hEFEFEFEF, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 3'b010, 32'h404, 32'hCAFEF00D, 32'h0,        4'hF,    32'h404, 32'hCAFEF00D, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 3'b110, 32'h10C, 32'h55AA55AA, 32'h0,        4'hF,    32'h10C, 32'h55AA55AA, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 3'b011, 32'h108, 32'h0,        32'h11223344, 4'hF,    32'h108, 32'h0,        1'b1, 32'h11223344};

        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        addr = '0; wdata = '0; size_f3 = 3'b010;
        bus_ready = 1'b0; bus_rdata = '0; bus_err = 1'b0;
        tick(); tick();
        check("rst mem_complete", 32'(mem_complete), 32'd0);
        check("rst mem_fault",    32'(mem_fault),    32'd0);
        check("rst cause",        32'(mem_fault_cause), 32'd0);
        check("rst rdata",        rdata,             32'd0);
        check("rst bus_valid",    32'(bus_valid),    32'd0);
        check("rst bus_write",    32'(bus_write),    32'd0);
        check("rst bus_addr",     bus_addr,          32'd0);
        check("rst bus_be",       32'(bus_be),       32'd0);
        check("rst bus_wdata",    bus_wdata,         32'd0);
        rst_n = 1'b1;
        tick();

        // Table: request at N, valid at N+1 with ready, completion at N+2
        for (int i = 0; i < 11; i++) begin
            mem_read  = ~vecs[i].we;
            mem_write = vecs[i].we;
            size_f3   = vecs[i].f3;
            addr      = vecs[i].addr;
            wdata     = vecs[i].wdata;
            tick();
            check($sformatf("v%0d bus_valid", i), 32'(bus_valid), 32'd1);
            check($sformatf("v%0d bus_write", i), 32'(bus_write), 32'(vecs[i].we));
            check($sformatf("v%0d bus_be", i),    32'(bus_be),    32'(vecs[i].be));
            check($sformatf("v%0d bus_addr", i),  bus_addr,       vecs[i].baddr);
            check($sformatf("v%0d bus_wdata", i), bus_wdata,      vecs[i].bwdata);
            check($sformatf("v%0d early complete", i), 32'(mem_complete), 32'd0);
            bus_ready = 1'b1;
            bus_rdata = vecs[i].brdata;
            tick();
            check($sformatf("v%0d complete", i),  32'(mem_complete), 32'd1);
            check($sformatf("v%0d fault", i),     32'(mem_fault),    32'd0);
            check($sformatf("v%0d valid off", i), 32'(bus_valid),    32'd0);
            if (vecs[i].chk_rd) check($sformatf("v%0d rdata", i), rdata, vecs[i].rd);
            mem_read = 1'b0; mem_write = 1'b0; bus_ready = 1'b0;
            tick();
            check($sformatf("v%0d complete pulse", i), 32'(mem_complete), 32'd0);
        end

        // Misaligned LW and LH: fault at N+1, no bus activity
        mem_read = 1'b1; size_f3 = 3'b010; addr = 32'h101;
        tick();
        check("mis lw fault", 32'(mem_fault), 32'd1);
        check("mis lw cause", 32'(mem_fault_cause), 32'd0);
        check("mis lw valid", 32'(bus_valid), 32'd0);
        mem_read = 1'b0;
        tick();
        check("mis lw fault pulse", 32'(mem_fault), 32'd0);
        check("mis lw no complete", 32'(mem_complete), 32'd0);
        check("mis lw valid after", 32'(bus_valid), 32'd0);
        mem_read = 1'b1; size_f3 = 3'b001; addr = 32'h103;
        tick();
        check("mis lh fault", 32'(mem_fault), 32'd1);
        check("mis lh valid", 32'(bus_valid), 32'd0);
        mem_read = 1'b0;
        tick();

`ifdef MEM_BUS_UNIT_TIMEOUT_EN
        // Ready never arrives: four BUSY cycles, then timeout fault
        mem_read = 1'b1; size_f3 = 3'b010; addr = 32'hA00;
        tick();
        for (int c = 0; c < 4; c++) begin
            check($sformatf("tmo valid c%0d", c), 32'(bus_valid), 32'd1);
            check($sformatf("tmo no fault c%0d", c), 32'(mem_fault), 32'd0);
            tick();
        end
        check("tmo fault", 32'(mem_fault), 32'd1);
        check("tmo cause", 32'(mem_fault_cause), 32'd2);
        check("tmo valid off", 32'(bus_valid), 32'd0);
        mem_read = 1'b0;
        tick();
`else
        // Ten stalled cycles, then an error response
        mem_read = 1'b1; size_f3 = 3'b010; addr = 32'h500;
        tick();
        for (int c = 0; c < 10; c++) begin
            check($sformatf("stall valid c%0d", c), 32'(bus_valid), 32'd1);
            check($sformatf("stall addr c%0d", c),  bus_addr, 32'h500);
            check($sformatf("stall be c%0d", c),    32'(bus_be), 32'hF);
            tick();
        end
        bus_ready = 1'b1; bus_err = 1'b1;
        tick();
        check("err fault", 32'(mem_fault), 32'd1);
        check("err cause", 32'(mem_fault_cause), 32'd1);
        check("err no complete", 32'(mem_complete), 32'd0);
        check("err valid off", 32'(bus_valid), 32'd0);
        check("err rdata kept", rdata, 32'h11223344);
        bus_ready = 1'b0; bus_err = 1'b0; mem_read = 1'b0;
        tick();
`endif

        // Request dropped in BUSY: silent completion, then a fresh LW
        mem_read = 1'b1; size_f3 = 3'b010; addr = 32'h600;
        tick();
        mem_read = 1'b0;
        tick();
        check("drop still valid", 32'(bus_valid), 32'd1);
        bus_ready = 1'b1; bus_rdata = 32'h99999999;
        tick();
        check("drop no complete", 32'(mem_complete), 32'd0);
        check("drop no fault", 32'(mem_fault), 32'd0);
        check("drop valid off", 32'(bus_valid), 32'd0);
        check("drop rdata kept", rdata, 32'h11223344);
        bus_ready = 1'b0; mem_read = 1'b1; addr = 32'h700;
        tick();
        check("second valid", 32'(bus_valid), 32'd1);
        check("second addr", bus_addr, 32'h700);
        check("second no early complete", 32'(mem_complete), 32'd0);
        bus_ready = 1'b1; bus_rdata = 32'h0BADF00D;
        tick();
        check("second complete", 32'(mem_complete), 32'd1);
        check("second rdata", rdata, 32'h0BADF00D);
        bus_ready = 1'b0; mem_read = 1'b0;
        tick();

        // Both requests high: the write wins
        mem_read = 1'b1; mem_write = 1'b1; size_f3 = 3'b010;
        addr = 32'h900; wdata = 32'h01020304;
        tick();
        check("both write", 32'(bus_write), 32'd1);
        check("both wdata", bus_wdata, 32'h01020304);
        bus_ready = 1'b1; bus_rdata = 32'h0;
        tick();
        check("both complete", 32'(mem_complete), 32'd1);
        bus_ready = 1'b0; mem_read = 1'b0; mem_write = 1'b0; wdata = '0;
        tick();

        // Reset during BUSY abandons the request
        mem_read = 1'b1; addr = 32'h800;
        tick();
        check("rstbusy valid", 32'(bus_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        check("rstbusy valid off", 32'(bus_valid), 32'd0);
        check("rstbusy rdata", rdata, 32'd0);
        rst_n = 1'b1; mem_read = 1'b0;
        tick();
        check("rstbusy idle valid", 32'(bus_valid), 32'd0);
        check("rstbusy no complete", 32'(mem_complete), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
